// File: rtl/inst_fetch_unit.sv
// IF stage: owns the PC, sequences the two-cycle instruction RAM read and
// loads the IF/ID register; handles stall, branch redirect, wrap and faults.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_enable,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES) - 32'd4;

  typedef enum logic [1:0] {
    SETUP = 2'b00,
    READ  = 2'b01,
    FAULT = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        imem_enable_q, imem_enable_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        target_legal_s;
  logic [31:0] pc_next_seq_s;

  assign target_legal_s = (branch_target[1:0] == 2'b00) && (branch_target <= LAST_PC);
  // Wrap by compare-and-clear so non-power-of-two memory sizes also work.
  assign pc_next_seq_s  = (pc_q >= LAST_PC) ? 32'h0000_0000 : (pc_q + 32'd4);

  // Next-state, PC and IF/ID update logic.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = 1'b0;
    fetch_fault_d = fetch_fault_q;
    fault_pc_d    = fault_pc_q;
    case (state_q)
      SETUP: begin
        if (branch_taken) begin
          if (target_legal_s) begin
            pc_d = branch_target;
          end else begin
            state_d       = FAULT;
            fetch_fault_d = 1'b1;
            fault_pc_d    = branch_target;
          end
        end else if (stall) begin
          state_d = SETUP;
        end else begin
          state_d = READ;
        end
      end
      READ: begin
        if (branch_taken) begin
          if (target_legal_s) begin
            pc_d    = branch_target;
            state_d = SETUP;
          end else begin
            state_d       = FAULT;
            fetch_fault_d = 1'b1;
            fault_pc_d    = branch_target;
          end
        end else if (stall) begin
          state_d = READ;
        end else begin
          ifid_instr_d = imem_data;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_next_seq_s;
          state_d      = SETUP;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = SETUP;
      end
    endcase
    // Enable is registered from the next state so it is high exactly in READ.
    imem_enable_d = (state_d == READ);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SETUP;
      pc_q          <= RESET_PC;
      imem_enable_q <= 1'b0;
      ifid_instr_q  <= 32'h0000_0000;
      ifid_pc_q     <= 32'h0000_0000;
      ifid_valid_q  <= 1'b0;
      fetch_fault_q <= 1'b0;
      fault_pc_q    <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      imem_enable_q <= imem_enable_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_fault_q <= fetch_fault_d;
      fault_pc_q    <= fault_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign imem_enable = imem_enable_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = ifid_valid_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_pc    = fault_pc_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- IF stage of the pipelined CPU, directly upstream of the instruction RAM.
- Owns the PC and drives the instruction RAM address and enable.
- Captures the returned 32-bit instruction into the IF/ID pipeline register.
- Handles stall, branch redirect/flush, PC wrap-around and fetch faults.

Parameters:
RESET_PC, 0, byte address loaded into PC on reset
MEM_BYTES, 256, instruction RAM size in bytes; legal PCs are 0..MEM_BYTES-4, word aligned

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
branch_taken  in  1  redirect request from EX
branch_target  in  32  redirect byte address
imem_addr  out  32  byte address to instruction RAM
imem_enable  out  1  instruction RAM read enable; RAM reads on its 0->1 edge
imem_data  in  32  instruction word from RAM, valid while imem_enable=1
ifid_instr  out  32  IF/ID instruction
ifid_pc  out  32  IF/ID address of that instruction
ifid_valid  out  1  one-cycle pulse: new instruction in IF/ID
fetch_fault  out  1  sticky fault flag
fault_pc  out  32  offending target address

Behaviour:
Interface:
- One clock, clk. Reset is synchronous and active-high, named reset.
- All state changes on the rising clk edge.

Reset (reset=1 at an edge):
- pc=RESET_PC, state=SETUP.
- ifid_instr=0, ifid_pc=0, ifid_valid=0, fetch_fault=0, fault_pc=0.
- imem_enable=0, imem_addr=RESET_PC.
- Reset overrides every other input.
- Reset mid-fetch or in FAULT discards everything and recovers cleanly.

Outputs by state:
- imem_addr = pc in all states.
- imem_enable = 1 only in READ.
- FSM states: SETUP, READ, FAULT.

Each fetch takes 2 cycles: SETUP (address stable, enable low), then READ (enable high, data captured at end).
- Steady state: one instruction every 2 cycles.
- First ifid_valid pulse appears 2 edges after reset deasserts.

SETUP:
- branch_taken and target legal: pc<=branch_target, stay SETUP.
- branch_taken and target illegal: go to FAULT.
- else stall: stay SETUP.
- else: go to READ.

READ:
- branch_taken (priority over stall):
  - Legal target: pc<=branch_target, no capture, ifid_valid<=0 (flush), go to SETUP.
  - Illegal target: go to FAULT.
- else stall: stay READ, enable held high, pc and IF/ID held, ifid_valid<=0.
- else capture:
  - ifid_instr<=imem_data, ifid_pc<=pc, ifid_valid<=1.
  - pc<=(pc+4) mod MEM_BYTES, go to SETUP.

ifid_valid:
- High for exactly the one cycle after a capture edge; 0 otherwise.
- ifid_instr and ifid_pc hold their value until the next capture.

Legal target:
- branch_target[1:0]==0 and branch_target<=MEM_BYTES-4.

FAULT:
- On entry: fetch_fault<=1, fault_pc<=branch_target, ifid_valid<=0.
- While in FAULT: imem_enable=0, pc frozen, stall and branch_taken ignored.
- Exit only via reset.

Wrap-around:
- Sequential fetch at pc=MEM_BYTES-4 wraps to 0; this is not a fault.
- Arithmetic is 32-bit unsigned; the wrap is done by compare-and-clear, not truncation.

Test Plan:
- Reset, then release with RAM word0=0xE3A01005, word1=0xE2811001, no stall:
  - imem_enable low, high, low, high.
  - imem_addr 0,0,4,4.
  - ifid_valid pulses with instr 0xE3A01005/pc 0, then 0xE2811001/pc 4.
- Assert stall for 3 cycles while in READ at pc=8:
  - imem_enable stays high, ifid_valid=0, pc stays 8.
  - After release, instr at 8 captured with ifid_pc=8.
- branch_taken=1, target 0x40, in READ at pc=12:
  - No capture, ifid_valid=0.
  - Next SETUP has imem_addr=0x40; next capture has ifid_pc=0x40.
- branch_taken and stall together in SETUP, target 0x20:
  - pc=0x20, branch wins.
- branch_target=0x42 (misaligned), then separately 0x100:
  - fetch_fault=1, fault_pc=0x42 (resp. 0x100), imem_enable=0.
  - Further branches ignored until reset; reset clears fault_pc to 0.
- Sequential fetch at pc=252:
  - Capture with ifid_pc=252; next imem_addr=0, no fault.
- Reset asserted during READ:
  - Next cycle pc=RESET_PC, ifid_valid=0, imem_enable=0.
